kernel_bank_pingpong: RTL and testbench

Double-buffered depthwise kernel weight store. Holds two banks of CHANNELS*KSIZE*KSIZE signed weights.
- The active bank drives the compute array via a flat parallel bus.
- The shadow bank is filled by a sequential auto-addressed valid/ready stream.
- A request/acknowledge swap lets the next layer's weights load while the current layer computes.

---
 rtl/kernel_bank_pkg.sv | 16 +
 rtl/kernel_bank_store.sv | 29 ++
 rtl/kernel_bank_pingpong.sv | 153 +++++++++++++++
 tb/tb_kernel_bank_pingpong.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/kernel_bank_pkg.sv
// Shared types and helpers for the double-buffered kernel weight store.
package kernel_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } kb_state_e;

  localparam int CSUM_W = 16;

  function automatic int total_weights(input int channels, input int ksize);
    return channels * ksize * ksize;
  endfunction

endpackage

// File: rtl/kernel_bank_store.sv
// One weight bank: register array with a single write port and a flat parallel read bus.
module kernel_bank_store #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 288,
  parameter int ADDR_W = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [DEPTH*DATA_W-1:0]   rd_bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    assign rd_bus[g*DATA_W +: DATA_W] = mem_q[g];
  end

endmodule

// File: rtl/kernel_bank_pingpong.sv
// Ping-pong depthwise kernel store: stream-filled shadow bank, req/ack swap into the active bank.
// Optional load checksum verification is enabled by defining KERNEL_CHECKSUM_EN.
module kernel_bank_pingpong
  import kernel_bank_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 32,
  parameter int KSIZE    = 3,
  localparam int TOTAL_W = total_weights(CHANNELS, KSIZE),
  localparam int PTR_W   = (TOTAL_W > 1) ? $clog2(TOTAL_W) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_start,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        shadow_full,
  input  logic                        swap_req,
  output logic                        swap_ack,
  output logic                        active_sel,
`ifdef KERNEL_CHECKSUM_EN
  input  logic [CSUM_W-1:0]           ld_csum,
  output logic                        csum_err,
`endif
  output logic [TOTAL_W*DATA_W-1:0]   kernel_out
);

  kb_state_e         state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              active_q, active_d;
  logic              swap_ack_q, swap_ack_d;
  logic              accept;
  logic              last_word;
  logic [TOTAL_W*DATA_W-1:0] bus0, bus1;

`ifdef KERNEL_CHECKSUM_EN
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic [CSUM_W-1:0] exp_q, exp_d;
  logic              err_q, err_d;
  logic [CSUM_W-1:0] word_ext;
  logic [CSUM_W-1:0] sum_next;

  assign word_ext = CSUM_W'($signed(ld_data));
  assign sum_next = sum_q + word_ext;
  assign csum_err = err_q;
`endif

  assign accept    = (state_q == ST_LOAD) && ld_valid;
  assign last_word = (ptr_q == PTR_W'(TOTAL_W - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    active_d   = active_q;
    swap_ack_d = 1'b0;
`ifdef KERNEL_CHECKSUM_EN
    sum_d = sum_q;
    exp_d = exp_q;
    err_d = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
`ifdef KERNEL_CHECKSUM_EN
          sum_d = '0;
          exp_d = ld_csum;
          err_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
          ptr_d = ptr_q + PTR_W'(1);
`ifdef KERNEL_CHECKSUM_EN
          sum_d = sum_next;
`endif
          if (last_word) begin
            ptr_d   = '0;
            state_d = ST_FULL;
`ifdef KERNEL_CHECKSUM_EN
            // A corrupt load never becomes swappable.
            if (sum_next != exp_q) begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
`endif
          end
        end
      end
      ST_FULL: begin
        if (swap_req) begin
          active_d   = ~active_q;
          swap_ack_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      active_q   <= 1'b0;
      swap_ack_q <= 1'b0;
`ifdef KERNEL_CHECKSUM_EN
      sum_q <= '0;
      exp_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      active_q   <= active_d;
      swap_ack_q <= swap_ack_d;
`ifdef KERNEL_CHECKSUM_EN
      sum_q <= sum_d;
      exp_q <= exp_d;
      err_q <= err_d;
`endif
    end
  end

  // Only the shadow bank (opposite of active) is ever written.
  kernel_bank_store #(.DATA_W(DATA_W), .DEPTH(TOTAL_W), .ADDR_W(PTR_W)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept && active_q),
    .wr_addr (ptr_q),
    .wr_data (ld_data),
    .rd_bus  (bus0)
  );

  kernel_bank_store #(.DATA_W(DATA_W), .DEPTH(TOTAL_W), .ADDR_W(PTR_W)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept && !active_q),
    .wr_addr (ptr_q),
    .wr_data (ld_data),
    .rd_bus  (bus1)
  );

  assign ld_ready    = (state_q == ST_LOAD);
  assign shadow_full = (state_q == ST_FULL);
  assign swap_ack    = swap_ack_q;
  assign active_sel  = active_q;
  assign kernel_out  = active_q ? bus1 : bus0;

endmodule

// File: tb/tb_kernel_bank_pingpong.sv
// Directed self-checking bench for kernel_bank_pingpong (CHANNELS=2, KSIZE=3).
module tb_kernel_bank_pingpong;

  localparam int DW = 8;
  localparam int NW = 18;
  localparam int KW = NW * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [DW-1:0] ld_data = '0;
  logic          shadow_full;
  logic          swap_req = 1'b0;
  logic          swap_ack;
  logic          active_sel;
  logic [KW-1:0] kernel_out;
  logic [15:0]   ld_csum = '0;
`ifdef KERNEL_CHECKSUM_EN
  logic          csum_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  kernel_bank_pingpong #(.DATA_W(DW), .CHANNELS(2), .KSIZE(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .shadow_full (shadow_full),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .active_sel  (active_sel),
`ifdef KERNEL_CHECKSUM_EN
    .ld_csum     (ld_csum),
    .csum_err    (csum_err),
`endif
    .kernel_out  (kernel_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] kvec(input int first, input int dir);
    logic [KW-1:0] v;
    v = '0;
    for (int j = 0; j < NW; j++) v[j*DW +: DW] = DW'(first + dir * j);
    return v;
  endfunction

  // Stream NW words first+dir*j; optional valid toggling, optional mid-load
  // check that the active bank is untouched, optional stray load_start.
  task automatic do_load(input int first, input int dir, input bit toggle,
                         input logic [15:0] csum, input bit chk_hold,
                         input logic [KW-1:0] hold, input bit stray_start);
    ld_csum    = csum;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("ld_ready_after_start", KW'(ld_ready), KW'(1));
    for (int j = 0; j < NW; j++) begin
      if (toggle) begin
        ld_valid = 1'b0;
        tick();
      end
      ld_valid   = 1'b1;
      ld_data    = DW'(first + dir * j);
      load_start = stray_start && (j == 5);
      tick();
      load_start = 1'b0;
      if (chk_hold && j == 8) check("kernel_hold_mid_load", kernel_out, hold);
    end
    ld_valid = 1'b0;
    ld_data  = '0;
  endtask

  task automatic do_swap(input bit exp_sel, input logic [KW-1:0] exp_k);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("swap_ack_pulse", KW'(swap_ack), KW'(1));
    check("active_sel_after_swap", KW'(active_sel), KW'(exp_sel));
    check("kernel_after_swap", kernel_out, exp_k);
    check("shadow_full_after_swap", KW'(shadow_full), KW'(0));
    tick();
    check("swap_ack_one_cycle", KW'(swap_ack), KW'(0));
  endtask

  initial begin
    // Reset and idle
    tick();
    tick();
    reset = 1'b0;
    check("rst_kernel", kernel_out, '0);
    check("rst_ld_ready", KW'(ld_ready), KW'(0));
    check("rst_active_sel", KW'(active_sel), KW'(0));
    check("rst_shadow_full", KW'(shadow_full), KW'(0));
    check("rst_swap_ack", KW'(swap_ack), KW'(0));

    swap_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_swap_ignored", KW'(swap_ack), KW'(0));
    end
    swap_req = 1'b0;
    tick();

    // Load 1..18 with toggling valid
    do_load(1, 1, 1'b1, 16'd171, 1'b0, '0, 1'b0);
    check("load1_shadow_full", KW'(shadow_full), KW'(1));
    check("load1_ld_ready_low", KW'(ld_ready), KW'(0));
    check("load1_kernel_still_zero", kernel_out, '0);
    do_swap(1'b1, kvec(1, 1));

    // Load -1..-18 while bank 1 active
    do_load(-1, -1, 1'b0, 16'hFF55, 1'b1, kvec(1, 1), 1'b0);
    check("load2_shadow_full", KW'(shadow_full), KW'(1));
    check("load2_kernel_unchanged", kernel_out, kvec(1, 1));
    do_swap(1'b0, kvec(-1, -1));

    // Reset after 7 of 18 words
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int j = 0; j < 7; j++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(50 + j);
      tick();
    end
    ld_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    check("midrst_kernel", kernel_out, '0);
    check("midrst_active_sel", KW'(active_sel), KW'(0));
    check("midrst_ld_ready", KW'(ld_ready), KW'(0));
    check("midrst_shadow_full", KW'(shadow_full), KW'(0));
    tick();
    check("midrst_still_idle", KW'(ld_ready), KW'(0));
    do_load(100, 1, 1'b0, 16'd1953, 1'b0, '0, 1'b0);
    do_swap(1'b1, kvec(100, 1));

    // swap_req held from load_start; stray load_start mid-load
    swap_req = 1'b1;
    do_load(20, 1, 1'b0, 16'd513, 1'b1, kvec(100, 1), 1'b1);
    check("held_no_ack_at_full", KW'(swap_ack), KW'(0));
    check("held_shadow_full", KW'(shadow_full), KW'(1));
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    swap_req   = 1'b0;
    check("held_swap_ack", KW'(swap_ack), KW'(1));
    check("held_active_sel", KW'(active_sel), KW'(0));
    check("held_kernel", kernel_out, kvec(20, 1));
    check("swapcycle_start_ignored", KW'(ld_ready), KW'(0));
    tick();
    check("held_ack_one_cycle", KW'(swap_ack), KW'(0));
    check("still_idle_after_swap", KW'(ld_ready), KW'(0));

`ifdef KERNEL_CHECKSUM_EN
    do_load(1, 1, 1'b0, 16'd171, 1'b0, '0, 1'b0);
    check("csum_good_full", KW'(shadow_full), KW'(1));
    check("csum_good_err", KW'(csum_err), KW'(0));
    do_swap(1'b1, kvec(1, 1));
    do_load(1, 1, 1'b0, 16'd170, 1'b0, '0, 1'b0);
    check("csum_bad_not_full", KW'(shadow_full), KW'(0));
    check("csum_bad_err", KW'(csum_err), KW'(1));
    check("csum_bad_idle", KW'(ld_ready), KW'(0));
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("csum_bad_no_swap", KW'(swap_ack), KW'(0));
    check("csum_bad_sel_kept", KW'(active_sel), KW'(1));
    check("csum_err_sticky", KW'(csum_err), KW'(1));
    ld_csum    = 16'd171;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("csum_err_cleared", KW'(csum_err), KW'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
